nd_rr_arb: RTL and testbench

- N-input, 1-output round-robin arbiter for message channels.
- Grants one pending input at a time into a single-entry output holding register, then drives the message downstream on one send channel.
- All channels use the 4-phase req/ack handshake.
- Sits in front of a shared node or link where more than two sources converge; it is the N-way scheduler counterpart to the fixed 2-to-1 merge nodes.

---
 rtl/nd_rr_arb_pkg.sv | 29 ++
 rtl/nd_rr_pick.sv | 31 +++
 rtl/nd_rr_arb.sv | 97 +++++++++
 tb/tb_nd_rr_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nd_rr_arb_pkg.sv
// Shared definitions for the N-way message nodes: switch values, message
// field sizes and offsets, output FSM states and small sizing helpers.
package nd_rr_arb_pkg;

   localparam logic NS_ON  = 1'b1;
   localparam logic NS_OFF = 1'b0;

   localparam int NS_ADDRESS_SIZE = 4;
   localparam int NS_DATA_SIZE    = 8;
   localparam int NS_REDUN_SIZE   = 4;

   // Message is packed {src,dst,dat,red}, src in the MSBs.
   localparam int NS_MSG_RED_OFS = 0;
   localparam int NS_MSG_DAT_OFS = NS_MSG_RED_OFS + NS_REDUN_SIZE;
   localparam int NS_MSG_DST_OFS = NS_MSG_DAT_OFS + NS_DATA_SIZE;
   localparam int NS_MSG_SRC_OFS = NS_MSG_DST_OFS + NS_ADDRESS_SIZE;

   typedef enum logic [1:0] {
      O_IDLE = 2'd0,
      O_REQ  = 2'd1,
      O_REL  = 2'd2
   } out_st_e;

   // Index width for an N-entry selector, never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nd_rr_pick.sv
// Rotating-priority picker: starting at ptr and wrapping modulo NI, the
// first set bit of pend wins. Purely combinational, shared by N-way nodes.
module nd_rr_pick
   import nd_rr_arb_pkg::*;
#(
   parameter int NI = 4,
   parameter int PW = idx_w(NI)
)(
   input  logic [NI-1:0] pend,
   input  logic [PW-1:0] ptr,
   output logic          gnt_vld,
   output logic [PW-1:0] gnt_idx
);

   // Walk the ring from the farthest slot back to ptr so the nearest
   // pending slot is the last (winning) assignment.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NI-1; k >= 0; k--) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NI) j = j - NI;
         if (pend[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/nd_rr_arb.sv
// N-input round-robin arbiter for 4-phase req/ack message channels. One
// input is granted at a time into a single output holding register, which
// is then offered downstream on the send channel.
module nd_rr_arb
   import nd_rr_arb_pkg::*;
#(
   parameter  int NI  = 4,
   parameter  int ASZ = NS_ADDRESS_SIZE,
   parameter  int DSZ = NS_DATA_SIZE,
   parameter  int RSZ = NS_REDUN_SIZE,
   localparam int MSZ = 2*ASZ + DSZ + RSZ,
   localparam int PW  = idx_w(NI)
)(
   input  logic            i_clk,
   input  logic            reset,
   output logic            ready,
   input  logic [NI-1:0]   rcv_req,
   output logic [NI-1:0]   rcv_ack,
   input  logic [NI*MSZ-1:0] rcv_msg,
   output logic            snd_req,
   input  logic            snd_ack,
   output logic [MSZ-1:0]  snd_msg,
   output logic [PW-1:0]   last_gnt
);

   logic          rg_rdy;
   logic [PW-1:0] ptr;
   out_st_e       state, state_nxt;
   logic [NI-1:0] pend;
   logic          gnt_vld;
   logic [PW-1:0] gnt_idx;
   logic          grant;

   // An input stays ineligible until its previous ack has been released.
   assign pend  = rcv_req & ~rcv_ack;
   assign grant = rg_rdy && (state == O_IDLE) && !snd_ack && gnt_vld;
   assign ready = rg_rdy;

   nd_rr_pick #(.NI(NI), .PW(PW)) u_pick (
      .pend    (pend),
      .ptr     (ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // Output FSM state register.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) state <= O_IDLE;
      else        state <= state_nxt;
   end

   // Output FSM next state; snd_req is asserted exactly while in O_REQ.
   always_comb begin
      state_nxt = state;
      snd_req   = 1'b0;
      case (state)
         O_IDLE: if (grant) state_nxt = O_REQ;
         O_REQ: begin
            snd_req = 1'b1;
            if (snd_ack) state_nxt = O_REL;
         end
         O_REL:  if (!snd_ack) state_nxt = O_IDLE;
         default: state_nxt = O_IDLE;
      endcase
   end

   // Init flag, RR pointer and the captured message of the winning input.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         rg_rdy   <= NS_OFF;
         ptr      <= '0;
         last_gnt <= '0;
         snd_msg  <= '0;
      end else begin
         rg_rdy <= NS_ON;
         if (grant) begin
            snd_msg  <= rcv_msg[gnt_idx*MSZ +: MSZ];
            last_gnt <= gnt_idx;
            ptr      <= (gnt_idx == PW'(NI-1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Per-input ack: set on grant, cleared once the source drops its req.
   // Independent of the FSM, so a release and a grant can share an edge.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         rcv_ack <= '0;
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (grant && (gnt_idx == PW'(i)))    rcv_ack[i] <= NS_ON;
            else if (rcv_ack[i] && !rcv_req[i]) rcv_ack[i] <= NS_OFF;
         end
      end
   end

endmodule

// File: tb/tb_nd_rr_arb.sv
// Directed bench for nd_rr_arb (NI=4) with hand-computed expectations.
module tb_nd_rr_arb;
   import nd_rr_arb_pkg::*;

   localparam int NI  = 4;
   localparam int MSZ = 2*NS_ADDRESS_SIZE + NS_DATA_SIZE + NS_REDUN_SIZE;
   localparam int PW  = 2;

   logic              i_clk = 1'b0;
   logic              reset = 1'b1;
   logic              ready;
   logic [NI-1:0]     rcv_req = '0;
   logic [NI-1:0]     rcv_ack;
   logic [NI*MSZ-1:0] rcv_msg;
   logic              snd_req;
   logic              snd_ack;
   logic [MSZ-1:0]    snd_msg;
   logic [PW-1:0]     last_gnt;

   logic [MSZ-1:0]    m [NI];

   // Downstream responder: raises ack one cycle after seeing snd_req,
   // drops it as soon as snd_req falls. Manual ack used when resp_en=0.
   logic resp_en = 1'b1, resp_ack = 1'b0, man_ack = 1'b0, seen = 1'b0;

   int total = 0;
   int bad   = 0;

   nd_rr_arb #(.NI(NI)) dut (
      .i_clk    (i_clk),
      .reset    (reset),
      .ready    (ready),
      .rcv_req  (rcv_req),
      .rcv_ack  (rcv_ack),
      .rcv_msg  (rcv_msg),
      .snd_req  (snd_req),
      .snd_ack  (snd_ack),
      .snd_msg  (snd_msg),
      .last_gnt (last_gnt)
   );

   always #5 i_clk = ~i_clk;

   always_comb begin
      rcv_msg = '0;
      for (int i = 0; i < NI; i++) rcv_msg[i*MSZ +: MSZ] = m[i];
   end

   always @(negedge i_clk) begin
      resp_ack = snd_req ? seen : 1'b0;
      seen     = snd_req;
   end

   assign snd_ack = resp_en ? resp_ack : man_ack;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drain();
      rcv_req = '0;
      resp_en = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      int g_idx [$];
      int g_cyc [$];
      int cyc, multi, stall_bad;
      logic prev;

      m[0] = 20'h0A001;
      m[1] = 20'h0B002;
      m[2] = 20'h00155;
      m[3] = 20'h0D004;

      // 1: reset, then one init edge before ready
      #2 reset = 1'b0;
      tick(); tick();
      chk("t1_rst_ready",   ready,    0);
      chk("t1_rst_sndreq",  snd_req,  0);
      chk("t1_rst_ack",     rcv_ack,  0);
      chk("t1_rst_msg",     snd_msg,  0);
      chk("t1_rst_lastgnt", last_gnt, 0);
      reset = 1'b1;
      chk("t1_ready_pre_edge", ready, 0);
      tick();
      chk("t1_ready",   ready,   1);
      chk("t1_sndreq",  snd_req, 0);
      chk("t1_ack",     rcv_ack, 0);

      // 2: single request on input 2
      rcv_req = 4'b0100;
      tick();
      chk("t2_ack",     rcv_ack,  4'b0100);
      chk("t2_sndreq",  snd_req,  1);
      chk("t2_msg",     snd_msg,  20'h00155);
      chk("t2_lastgnt", last_gnt, 2);
      rcv_req = 4'b0000;
      tick();
      chk("t2_ack_drop",   rcv_ack, 4'b0000);
      chk("t2_sndreq_hold", snd_req, 1);
      tick();
      chk("t2_sndreq_rel", snd_req, 0);
      tick();
      rcv_req = 4'b1001;
      tick();
      chk("t2_next_from3", last_gnt, 3);
      chk("t2_next_ack",   rcv_ack,  4'b1000);
      drain();

      // 3: all inputs requesting continuously
      cyc = 0; multi = 0; prev = snd_req;
      rcv_req = '1;
      for (int c = 0; c < 40 && g_idx.size() < 6; c++) begin
         tick();
         cyc++;
         if ($countones(rcv_ack) > 1) multi++;
         if (snd_req && !prev) begin
            g_idx.push_back(int'(last_gnt));
            g_cyc.push_back(cyc);
         end
         prev = snd_req;
         for (int i = 0; i < NI; i++) rcv_req[i] = !rcv_ack[i];
      end
      chk("t3_ngrant", g_idx.size(), 6);
      for (int k = 0; k < g_idx.size(); k++)
         chk($sformatf("t3_order%0d", k), g_idx[k], k % NI);
      for (int k = 1; k < g_cyc.size(); k++)
         chk($sformatf("t3_space%0d", k), g_cyc[k] - g_cyc[k-1], 4);
      chk("t3_single_ack", multi, 0);
      drain();

      // 4: downstream stall with inputs 1 and 3 pending (ptr is 2)
      resp_en = 1'b0; man_ack = 1'b0;
      rcv_req = 4'b1010;
      tick();
      chk("t4_first",     last_gnt, 3);
      chk("t4_first_msg", snd_msg,  m[3]);
      stall_bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (snd_req !== 1'b1 || snd_msg !== m[3] || rcv_ack !== 4'b1000) stall_bad++;
      end
      chk("t4_stall", stall_bad, 0);
      man_ack = 1'b1;
      tick();
      chk("t4_rel_sndreq", snd_req, 0);
      man_ack = 1'b0;
      tick();
      tick();
      chk("t4_second",     last_gnt, 1);
      chk("t4_second_msg", snd_msg,  m[1]);
      chk("t4_second_ack", rcv_ack,  4'b1010);
      chk("t4_second_req", snd_req,  1);

      // 5: asynchronous reset mid-cycle while in O_REQ
      #2 reset = 1'b0;
      #1;
      chk("t5_async_sndreq", snd_req,  0);
      chk("t5_async_ack",    rcv_ack,  0);
      chk("t5_async_ready",  ready,    0);
      chk("t5_async_msg",    snd_msg,  0);
      chk("t5_async_gnt",    last_gnt, 0);
      rcv_req = 4'b0001;
      tick(); tick();
      chk("t5_hold_ack", rcv_ack, 0);
      reset = 1'b1;
      tick();
      chk("t5_init_noack", rcv_ack, 0);
      chk("t5_init_ready", ready,   1);
      tick();
      chk("t5_gnt0",     last_gnt, 0);
      chk("t5_gnt0_ack", rcv_ack,  4'b0001);
      chk("t5_gnt0_msg", snd_msg,  m[0]);
      drain();

      // 6: ack release on input 0 and grant to input 2 on the same edge
      rcv_req = 4'b0001;
      tick();
      chk("t6_gnt0", rcv_ack, 4'b0001);
      tick(); tick(); tick();
      chk("t6_pre_ack", rcv_ack, 4'b0001);
      chk("t6_pre_req", snd_req, 0);
      rcv_req = 4'b0100;
      tick();
      chk("t6_ack_swap", rcv_ack,  4'b0100);
      chk("t6_msg",      snd_msg,  m[2]);
      chk("t6_gnt",      last_gnt, 2);
      chk("t6_sndreq",   snd_req,  1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
